wb_sram_slave: RTL and testbench
================================

// Module: wb_sram_slave
// PURPOSE
//  Wishbone B3 slave: single-port on-chip SRAM that answers the picorv32_wb master through wb_bus_b3.
//  Serves classic cycles, incrementing bursts and wrapping bursts (CTI/BTE), with byte-lane writes.
//  Sits in a bus slave slot next to aes_top; address decode happens in the bus, this block uses word offset only.
// PARAMETERS
//  AW        10   word-address width; memory depth = 2**AW x 32 bit (default 4 KiB)
//  INIT_ZERO 0    1: synthesis/sim init of memory to 0; 0: contents undefined after power-up
// PORTS
//  wb_clk_i   in   1   single clock, all logic rising-edge
//  wb_rst_i   in   1   reset, synchronous, active-high
//  wb_adr_i   in   32  byte address; bits [AW+1:2] used, rest ignored
//  wb_dat_i   in   32  write data
//  wb_sel_i   in   4   byte enables, bit n -> dat[8n+7:8n]
//  wb_we_i    in   1   1 write / 0 read
//  wb_cyc_i   in   1   cycle valid
//  wb_stb_i   in   1   strobe
//  wb_cti_i   in   3   cycle type: 000 classic, 010 incr burst, 111 end of burst
//  wb_bte_i   in   2   burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_dat_o   out  32  read data, registered
//  wb_ack_o   out  1   beat acknowledge, registered
//  wb_err_o   out  1   error termination, registered
//  wb_rty_o   out  1   tied 0
// BEHAVIOUR
//  Reset: ack_o=0, err_o=0, dat_o=0, state=IDLE, beat address=0; memory not cleared. Reset wins over any request;
//   a write pending in the reset cycle is suppressed. Reset mid-burst -> ack_o=0 next cycle, IDLE.
//  Beat accepted = cyc_i & stb_i & ack_o. Writes commit only on an accepted beat: mem[addr] byte lanes per sel_i.
//  States: IDLE, ACK, WAIT, ERR.
//   IDLE: cyc&stb -> addr<=adr_i[AW+1:2], dat_o<=mem[adr], ack_o<=1, -> ACK (1 wait state; first ack 2nd cycle).
//         cyc&stb with CTI in {001,011,100,101,110} -> err_o<=1 one cycle, -> ERR; no memory access.
//   ACK (accepted beat): CTI 000 or 111 -> ack_o<=0, -> IDLE. CTI 010 -> addr<=next(addr,bte),
//         dat_o<=mem[next], ack_o stays 1 (one beat per cycle, zero wait states).
//       stb_i=0 while cyc_i=1 -> ack_o<=0, -> WAIT, addr held. cyc_i=0 -> ack_o<=0, -> IDLE.
//   WAIT: stb_i=1 -> dat_o<=mem[addr], ack_o<=1, -> ACK. cyc_i=0 -> IDLE.
//   ERR: err_o<=0, -> IDLE (err_o high exactly one cycle per request).
//  next(): linear addr+1 mod 2**AW; wrapK: low log2(K) bits increment mod K, upper bits held.
//  Read-during-write: a write beat and the next read beat target different words; no bypass needed.
//  Classic ack deasserts after one cycle so a held stb never gets a double ack.
// CONFIGURATION
//  WB_SRAM_BURST_EN defined: CTI/BTE decoded as above; reserved CTI -> err_o.
//  Not defined: every request treated as classic (CTI/BTE ignored), 2 cycles per beat
//   (request->ack->ack low), err_o tied 0, WAIT state and next() logic removed.
// STRUCTURE
//  Shared package wb_b3_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB, BTE_LINEAR/WRAP4/WRAP8/WRAP16 constants,
//   slave state encoding type.
//  Sub-module wb_sram_mem: 2**AW x 32 synchronous 1RW RAM, 4 byte-write enables, registered read.
//  Top: FSM, beat-address counter, wrap logic, ack/err registers.
// TESTING
//  1 Classic write 0xDEADBEEF @0x10 sel=1111 then classic read @0x10 -> ack 1 cycle each, dat_o=0xDEADBEEF.
//  2 Byte write 0xAA @0x10 sel=0010 over 0x00000000 -> read returns 0x0000AA00; other lanes untouched.
//  3 Incr burst linear, 4 writes @0x100 (CTI 010,010,010,111) data 1..4, then read burst -> acks on
//    4 consecutive cycles after 1 wait, dat_o=1,2,3,4; ack_o low cycle after CTI=111 beat.
//  4 Wrap4 read burst starting @0x108 -> words returned in order 0x108,0x10C,0x100,0x104.
//  5 stb_i dropped 2 cycles mid-burst at beat 2 -> ack_o low, resumes with beat 2 data after 1 wait; no
//    beat skipped or duplicated; cyc_i dropped mid-burst -> IDLE, next classic access normal.
//  6 CTI=011 request -> err_o=1 for exactly 1 cycle, ack_o=0, memory unchanged; reset asserted during
//    burst write -> next cycle ack_o=0 and the in-flight write not committed.

Source files
------------

// File: rtl/wb_b3_pkg.sv
// wb_b3_pkg: Wishbone B3 cycle/burst type constants and the
// SRAM slave state encoding shared by the wb_sram_* files.
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_ERR
    } wb_slv_state_e;

    // Cycle types this slave does not serve (const/prefetch/user codes)
    function automatic logic cti_reserved(input logic [2:0] cti);
        return !((cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_EOB));
    endfunction

endpackage

// File: rtl/wb_sram_mem.sv
// wb_sram_mem: 2**AW x 32 single-port RAM, byte write enables,
// registered read port cleared by reset. INIT_ZERO=1 zero-fills.
module wb_sram_mem #(
    parameter int AW        = 10,
    parameter int INIT_ZERO = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 1 << AW;

    if (INIT_ZERO != 0) begin : g_zero
        logic [31:0] mem_q [DEPTH] = '{default: '0};
        logic [31:0] rd_q;

        // Byte-lane writes
        always_ff @(posedge clk_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end

        // Registered read, cleared by reset
        always_ff @(posedge clk_i) begin
            if (rst_i) rd_q <= '0;
            else if (re_i) rd_q <= mem_q[addr_i];
        end

        assign rdata_o = rd_q;
    end else begin : g_undef
        logic [31:0] mem_q [DEPTH];
        logic [31:0] rd_q;

        // Byte-lane writes
        always_ff @(posedge clk_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end

        // Registered read, cleared by reset
        always_ff @(posedge clk_i) begin
            if (rst_i) rd_q <= '0;
            else if (re_i) rd_q <= mem_q[addr_i];
        end

        assign rdata_o = rd_q;
    end

endmodule

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B3 SRAM slave. Define WB_SRAM_BURST_EN for
// CTI/BTE bursts and err_o on reserved CTI; otherwise classic only.
module wb_sram_slave
    import wb_b3_pkg::*;
#(
    parameter int AW        = 10,
    parameter int INIT_ZERO = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    logic [AW-1:0] adr_w;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] mem_addr;
    logic          ack_q;
    logic          err_q;
    logic          req;
    logic          beat;
    logic          cti_incr;
    logic          cti_bad;
    logic          mem_re;
    logic [3:0]    mem_we;
    wb_slv_state_e state_q;
    logic          unused_ok;

    assign adr_w     = wb_adr_i[AW+1:2];
    assign req       = wb_cyc_i & wb_stb_i;
    assign beat      = req & ack_q;
    assign mem_we    = (beat & wb_we_i & ~wb_rst_i) ? wb_sel_i : 4'b0000;
    assign unused_ok = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], wb_cti_i, wb_bte_i};

`ifdef WB_SRAM_BURST_EN
    assign cti_incr = (wb_cti_i == CTI_INCR);
    assign cti_bad  = cti_reserved(wb_cti_i);

    // Next burst word: linear walks the whole array, wrapK only low bits
    always_comb begin
        addr_nxt = addr_q + 1'b1;
        unique case (1'b1)
            (wb_bte_i == BTE_WRAP4):
                addr_nxt = {addr_q[AW-1:2], addr_q[1:0] + 2'd1};
            (wb_bte_i == BTE_WRAP8):
                addr_nxt = {addr_q[AW-1:3], addr_q[2:0] + 3'd1};
            (wb_bte_i == BTE_WRAP16):
                addr_nxt = {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
            default: ;
        endcase
    end
`else
    assign cti_incr = 1'b0;
    assign cti_bad  = 1'b0;
    assign addr_nxt = addr_q;
`endif

    // One RAM port: writes use the beat address, reads prefetch the word
    // that the next ack will present
    always_comb begin
        mem_addr = addr_q;
        mem_re   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                mem_addr = adr_w;
                mem_re   = req & ~cti_bad;
            end
            ST_ACK: begin
                if (beat & cti_incr & ~wb_we_i) begin
                    mem_addr = addr_nxt;
                    mem_re   = 1'b1;
                end
            end
            ST_WAIT: mem_re = req;
            default: ;
        endcase
    end

    // Beat FSM with registered ack/err and the burst address counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req && cti_bad) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (req) begin
                        addr_q  <= adr_w;
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
`ifdef WB_SRAM_BURST_EN
                    if (!wb_cyc_i) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!wb_stb_i) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end else if (cti_incr) begin
                        addr_q  <= addr_nxt;
                    end else begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`else
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (wb_stb_i) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ERR: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wb_sram_mem #(
        .AW        (AW),
        .INIT_ZERO (INIT_ZERO)
    ) u_mem (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .re_i    (mem_re),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (wb_dat_i),
        .rdata_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: table vectors, random traffic against a word-array
// model, and hand sequences for stall/abort/error/reset corners.
`timescale 1ns/1ps
module tb_wb_sram_slave;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam logic [2:0] C_CLASSIC = 3'b000;
    localparam logic [2:0] C_INCR    = 3'b010;
    localparam logic [2:0] C_EOB     = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        rty;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [DEPTH];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [15];

    always #5 clk = ~clk;

    wb_sram_slave #(.AW(AW), .INIT_ZERO(0)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int word(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int next_word(int w, logic [1:0] b);
        int k;
        case (b)
            2'b01:   k = 4;
            2'b10:   k = 8;
            2'b11:   k = 16;
            default: k = 0;
        endcase
        if (k == 0) return (w + 1) % DEPTH;
        return (w - (w % k)) + ((w % k) + 1) % k;
    endfunction

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cti = C_CLASSIC; bte = 2'b00; sel = 4'h0;
    endtask

    task automatic classic(input string name, input bit w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           input logic [2:0] c, input bit chk_rd,
                           input logic [31:0] exp_rd);
        int lat;
        lat = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        cti = c; bte = 2'b00;
        do begin
            step();
            lat++;
        end while (ack !== 1'b1 && lat < 16);
        check({name, " ack latency"}, lat, 1);
        if (chk_rd) check({name, " rdata"}, rdat, exp_rd);
        step();
        check({name, " ack single"}, {31'b0, ack}, 0);
        if (w) model[word(a)] = merge(model[word(a)], d, s);
        idle();
    endtask

    task automatic present(input int wd, input logic [31:0] d,
                           input logic [3:0] s, input bit last);
        adr  = 32'(wd) << 2;
        wdat = d;
        sel  = s;
        cti  = last ? C_EOB : C_INCR;
    endtask

    task automatic burst(input string name, input bit w, input int start,
                         input logic [1:0] b, input int n, input bit seq,
                         input int stall_at, input int stall_len,
                         input int abort_after);
        int ew [$];
        logic [31:0] bd [$];
        logic [3:0] bs [$];
        int cur, i, guard, last_acc, stall_cnt, n_eff, exp_gap;
        bit a_s, s_s;
        logic [31:0] d_s;
        cur = start;
        for (int k = 0; k < n; k++) begin
            ew.push_back(cur);
            bd.push_back(seq ? 32'(k + 1) : $urandom);
            bs.push_back((w && !seq) ? 4'($urandom_range(1, 15)) : 4'hF);
            cur = next_word(cur, b);
        end
        n_eff = (abort_after > 0) ? abort_after : n;
        i = 0; guard = 0; last_acc = 0; stall_cnt = 0;
        cyc = 1'b1; stb = 1'b1; we = w; bte = b;
        present(ew[0], bd[0], bs[0], n == 1);
        while (i < n_eff && guard < 200) begin
            a_s = ack; d_s = rdat; s_s = stb;
            step();
            guard++;
            if (a_s && s_s) begin
                exp_gap = (i == 0) ? 2 : ((i == stall_at) ? stall_len + 2 : 1);
                check({name, " beat gap"}, guard - last_acc, exp_gap);
                last_acc = guard;
                if (w) model[ew[i]] = merge(model[ew[i]], bd[i], bs[i]);
                else check({name, " beat data"}, d_s, model[ew[i]]);
                i++;
                if (i < n_eff) begin
                    present(ew[i], bd[i], bs[i], i == n - 1);
                    if (i == stall_at && stall_len > 0) begin
                        stb = 1'b0;
                        stall_cnt = stall_len;
                    end
                end
            end else if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) begin
                    check({name, " ack low in stall"}, {31'b0, ack}, 0);
                    stb = 1'b1;
                end
            end
        end
        check({name, " beats"}, i, n_eff);
        if (n_eff < n) begin
            cyc = 1'b0; stb = 1'b0;
            step();
        end
        check({name, " ack low after"}, {31'b0, ack}, 0);
        idle();
    endtask

    initial begin
        rst = 1'b1; adr = '0; wdat = '0;
        idle();
        step(); step(); step();
        check("reset ack", {31'b0, ack}, 0);
        check("reset err", {31'b0, err}, 0);
        check("reset rty", {31'b0, rty}, 0);
        check("reset dat", rdat, 0);
        rst = 1'b0;
        step();

        for (int wd = 0; wd < 160; wd++)
            classic("prefill", 1'b1, 32'(wd) << 2, 4'hF, $urandom, C_CLASSIC, 1'b0, 0);

        vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h0,         32'h0};
        vt[3]  = '{1'b1, 32'h0000_0010, 4'h2, 32'hFFFF_AAFF, 32'h0};
        vt[4]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h0000_AA00};
        vt[5]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h5566_7788, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0014, 4'h9, 32'hAABB_CCDD, 32'h0};
        vt[7]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'hAA66_77DD};
        vt[8]  = '{1'b0, 32'hFFFF_0010, 4'hF, 32'h0,         32'h0000_AA00};
        vt[9]  = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0BAD_F00D, 32'h0};
        vt[10] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'h0BAD_F00D};
        vt[11] = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 32'h0};
        vt[12] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h1234_5678};
        vt[13] = '{1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vt[14] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         32'hAA66_77DD};
        for (int v = 0; v < 15; v++)
            classic($sformatf("vec%0d", v), vt[v].w, vt[v].a, vt[v].s, vt[v].d,
                    C_CLASSIC, !vt[v].w, vt[v].exp);

        for (int r = 0; r < 150; r++) begin
            bit rw;
            int wd;
            logic [31:0] a;
            rw = 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 127);
            a  = ($urandom & 32'hFFFF_F000) | (32'(wd) << 2) | 32'($urandom_range(0, 3));
            classic("rand classic", rw, a, 4'($urandom), $urandom, C_CLASSIC, !rw, model[wd]);
        end

        // reset lands on the accepting cycle of a classic write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h24; sel = 4'hF;
        wdat = ~model[9]; cti = C_CLASSIC;
        step();
        check("rst classic ack", {31'b0, ack}, 1);
        rst = 1'b1;
        step();
        check("rst classic ack low", {31'b0, ack}, 0);
        check("rst classic dat", rdat, 0);
        rst = 1'b0;
        idle();
        step();
        classic("rst classic no write", 1'b0, 32'h24, 4'hF, 0, C_CLASSIC, 1'b1, model[9]);

`ifdef WB_SRAM_BURST_EN
        burst("t3 wr", 1'b1, 64, 2'b00, 4, 1'b1, -1, 0, 0);
        burst("t3 rd", 1'b0, 64, 2'b00, 4, 1'b0, -1, 0, 0);
        check("t3 word2", model[66], 3);
        burst("t4 wrap4", 1'b0, 66, 2'b01, 4, 1'b0, -1, 0, 0);
        burst("wrap8", 1'b0, 77, 2'b10, 8, 1'b0, -1, 0, 0);
        burst("wrap16", 1'b0, 91, 2'b11, 16, 1'b0, -1, 0, 0);
        burst("lin end wr", 1'b1, DEPTH - 2, 2'b00, 4, 1'b0, -1, 0, 0);
        burst("lin end rd", 1'b0, DEPTH - 2, 2'b00, 4, 1'b0, -1, 0, 0);
        burst("t5 stall rd", 1'b0, 64, 2'b00, 4, 1'b0, 2, 2, 0);
        burst("t5 stall wr", 1'b1, 120, 2'b01, 4, 1'b0, 1, 1, 0);
        burst("t5 stall chk", 1'b0, 120, 2'b01, 4, 1'b0, -1, 0, 0);
        burst("t5 abort", 1'b0, 100, 2'b00, 6, 1'b0, -1, 0, 2);
        classic("t5 after abort", 1'b0, 32'(103) << 2, 4'hF, 0, C_CLASSIC, 1'b1, model[103]);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF;
        wdat = ~model[8]; cti = 3'b011;
        step();
        check("t6 err high", {31'b0, err}, 1);
        check("t6 err no ack", {31'b0, ack}, 0);
        idle();
        step();
        check("t6 err one cycle", {31'b0, err}, 0);
        check("t6 err late ack", {31'b0, ack}, 0);
        classic("t6 mem unchanged", 1'b0, 32'h20, 4'hF, 0, C_CLASSIC, 1'b1, model[8]);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = 2'b00;
        present(90, 32'hA000_0000, 4'hF, 1'b0);
        step();
        check("t6 rstb ack", {31'b0, ack}, 1);
        step();
        check("t6 rstb beat0", {31'b0, ack}, 1);
        model[90] = 32'hA000_0000;
        present(91, 32'hA111_1111, 4'hF, 1'b0);
        step();
        check("t6 rstb beat1", {31'b0, ack}, 1);
        model[91] = 32'hA111_1111;
        present(92, ~model[92], 4'hF, 1'b0);
        rst = 1'b1;
        step();
        check("t6 rstb ack low", {31'b0, ack}, 0);
        check("t6 rstb dat", rdat, 0);
        rst = 1'b0;
        idle();
        step();
        classic("t6 rstb w91", 1'b0, 32'(91) << 2, 4'hF, 0, C_CLASSIC, 1'b1, model[91]);
        classic("t6 rstb w92", 1'b0, 32'(92) << 2, 4'hF, 0, C_CLASSIC, 1'b1, model[92]);

        for (int r = 0; r < 40; r++) begin
            int n, sa;
            n  = $urandom_range(1, 8);
            sa = (n > 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            burst("rand burst", 1'($urandom_range(0, 1)), $urandom_range(0, 127),
                  2'($urandom_range(0, 3)), n, 1'b0, sa, $urandom_range(1, 3), 0);
        end
`else
        classic("cti ignored wr", 1'b1, 32'h20, 4'hF, 32'hC0FF_EE00, 3'b011, 1'b0, 0);
        check("cti ignored err", {31'b0, err}, 0);
        classic("cti ignored rd", 1'b0, 32'h20, 4'hF, 0, C_INCR, 1'b1, 32'hC0FF_EE00);
        check("incr as classic err", {31'b0, err}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
